// File: rtl/poly_decim_fir_if.sv
// rtl/poly_decim_fir_if.sv - sample, coefficient and output signal bundle for poly_decim_fir
// Ports (signals):
//   in_valid/in_ready/in_data         sample handshake into the filter
//   coef_we/coef_addr/coef_wdata      coefficient write port, coef_busy while filtering
//   out_valid/out_data/out_sat        decimated output strobe, value and saturation flag
// Modports: master drives samples/coefficients, slave is the filter.
interface poly_decim_fir_if #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 10,
  parameter int NTAPS  = 16,
  parameter int OUT_W  = 17
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_W-1:0]     in_data;
  logic                       coef_we;
  logic [$clog2(NTAPS)-1:0]   coef_addr;
  logic signed [COEF_W-1:0]   coef_wdata;
  logic                       coef_busy;
  logic                       out_valid;
  logic signed [OUT_W-1:0]    out_data;
  logic                       out_sat;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
    input  in_ready, coef_busy, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
    output in_ready, coef_busy, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/poly_decim_fir.sv
// rtl/poly_decim_fir.sv - decimate-by-DEC FIR stage with one time-multiplexed MAC
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   clr     synchronous clear of history/phase/FSM, coefficients and out_data kept
//   bus     poly_decim_fir_if.slave: sample handshake, coefficient writes, output strobe
module poly_decim_fir #(
  parameter int IN_W   = 8,
  parameter int COEF_W = 10,
  parameter int NTAPS  = 16,
  parameter int DEC    = 4,
  parameter int OUT_W  = 17,
  parameter int SHIFT  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  poly_decim_fir_if.slave bus
);

  localparam int AW     = $clog2(NTAPS);
  localparam int PW     = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  // Rounding constant 2^(SHIFT-1), zero when SHIFT==0.
  localparam logic [ACC_W:0] RND = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
  // Output clamp limits expressed at the widened accumulator width.
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  logic [1:0]               state;
  logic [PW-1:0]            phase;
  logic [AW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [IN_W-1:0]   hist [NTAPS];
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic                     out_valid_q;
  logic                     out_sat_q;
  logic signed [OUT_W-1:0]  out_data_q;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rsum;
  logic signed [ACC_W:0]    rsh;
  logic                     sat_hi;
  logic                     sat_lo;

  assign prod   = hist[k] * coef[k];
  // One guard bit so adding the rounding constant cannot wrap.
  assign rsum   = {acc[ACC_W-1], acc} + $signed(RND);
  assign rsh    = rsum >>> SHIFT;
  assign sat_hi = (rsh > OUT_MAX);
  assign sat_lo = (rsh < OUT_MIN);

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.coef_busy = (state != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase       <= '0;
      k           <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
    end else if (clr) begin
      state       <= S_IDLE;
      phase       <= '0;
      k           <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) hist[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int i = NTAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= bus.in_data;
            if (phase == PW'(DEC - 1)) begin
              phase <= '0;
              acc   <= '0;
              k     <= '0;
              state <= S_MAC;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc <= acc + {{AW{prod[PROD_W-1]}}, prod};
          k   <= k + 1'b1;
          if (k == AW'(NTAPS - 1)) state <= S_ROUND;
        end
        S_ROUND: begin
          if (sat_hi)      out_data_q <= OUT_MAX[OUT_W-1:0];
          else if (sat_lo) out_data_q <= OUT_MIN[OUT_W-1:0];
          else             out_data_q <= rsh[OUT_W-1:0];
          out_sat_q   <= sat_hi | sat_lo;
          out_valid_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Coefficients survive clr; writes only land while idle so a running MAC sees a stable set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else if (!clr && bus.coef_we && (state == S_IDLE)) begin
      coef[bus.coef_addr] <= bus.coef_wdata;
    end
  end

endmodule
